wb_openram_banked_bridge: RTL and testbench
===========================================

# wb_openram_banked_bridge

Parametrised Wishbone-classic slave that maps a contiguous address window onto NUM_BANKS OpenRAM single-port macros (sky130 1rw1r, port 0 used). It sits between the Caravel management Wishbone bus and the SRAM macros in user_project_wrapper. It generalises the single-bank bridge with bank decoding, a programmable base address, byte-masked writes, configurable read wait states and cycle-abort handling.

## Interface

Parameters:
- BASE_ADDR, 32'h3000_0000: byte base of window; must be aligned to window size.
- NUM_BANKS, 2: macro count; power of two, 1..8.
- ADDR_WIDTH, 8: word-address bits per macro (256 words).
- DATA_WIDTH, 32: fixed at 32, four byte lanes.
- RD_WAIT, 0: extra cycles between SRAM sample edge and read-data capture; 0..3.

Ports:
- wb_clk_i  in  1  sole clock; also driven out as SRAM clk0.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone control.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- clk0  out  NUM_BANKS  per-bank clock (all = wb_clk_i).
- csb0  out  NUM_BANKS  per-bank chip select, active-low.
- web0  out  1  shared write enable, active-low.
- wmask0  out  4  shared byte write mask.
- addr0  out  ADDR_WIDTH  shared word address.
- din0  out  32  shared write data.
- dout0  in  NUM_BANKS*32  per-bank read data, bank b at [32b+31:32b].

## Operation

- Window: WIN_BITS = ADDR_WIDTH+2+log2(NUM_BANKS). Hit = cyc & stb & (adr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]). Word = adr[ADDR_WIDTH+1:2]; bank = adr[WIN_BITS-1:ADDR_WIDTH+2]; adr[1:0] ignored.
- Miss: no SRAM access, no ack (another slave may decode).
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, ACK.
- IDLE: on hit, register addr0, din0 = dat_i, wmask0 = we ? sel : 0, web0 = ~we, bank index; -> ISSUE.
- ISSUE: csb0[bank] = 0 for exactly this cycle, other banks 1; macro samples at the closing edge. Write -> ACK. Read -> WAIT if RD_WAIT>0, else CAPTURE.
- WAIT: counter counts RD_WAIT cycles -> CAPTURE.
- CAPTURE: wbs_dat_o <= dout0 slice of registered bank -> ACK.
- ACK: wbs_ack_o = 1 for one cycle -> IDLE. A request can be accepted in the following IDLE cycle.
- Write with sel = 4'b0000: access issued with wmask0 = 0, memory unchanged, still acked.
- wbs_dat_o holds last read data until the next read capture; unchanged by writes.
- Abort: cyc_i low in WAIT or CAPTURE -> IDLE, no ack, dat_o not updated. cyc_i low in ISSUE -> access completes, including write commit, then IDLE without ack.
- Reset values: wbs_ack_o 0, wbs_dat_o 0, csb0 all 1, web0 1, wmask0 0, addr0 0, din0 0, state IDLE, counter 0.

## Timing

- Request seen in IDLE at edge T0. csb0 is low in cycle T0..T1.
- Write ack in cycle T2..T3: 3-cycle transaction.
- Read: data captured at edge T2+RD_WAIT, ack in the following cycle. Total 4+RD_WAIT cycles.
- All outputs are registered. No combinational path from Wishbone inputs to any output.
- Reset assert is immediate, release is synchronous via the flop. Reset mid-transaction drops csb0 high at once, and no ack follows.

## Structure

- Package wb_openram_pkg: state enum, SRAM_DW = 32, SEL_W = 4, helper function for WIN_BITS/bank-bit computation.
- Sub-module wb_openram_rdmux: registered NUM_BANKS:1 read-data select used in CAPTURE.
- Top instantiates the FSM inline. user_project_wrapper instantiates NUM_BANKS macros and splits the shared buses to each.

## Test plan

- Reset: hold wb_rst_ni low, drive a hit. Required: csb0 = all 1s, ack 0, dat_o 0.
- Write then read: write 0xDEADBEEF to BASE+0x404, NUM_BANKS=2, ADDR_WIDTH=8. Required: csb0[1] low for one cycle, addr0 = 0x01, ack 3 cycles after request. Read back: ack after 4 cycles, dat_o = 0xDEADBEEF.
- Byte mask: write 0x11223344 with sel 1111, then 0xAABBCCDD with sel 0101. Required: wmask0 = 0101, read returns 0x11BB33DD.
- RD_WAIT=2: read from bank 0. Required: ack 6 cycles after request, correct data.
- Miss: adr = BASE+window size. Required: no csb0 low, no ack for 10 cycles.
- Abort and back-to-back: drop cyc during WAIT. Required: no ack, state returns to IDLE. A new read issued immediately afterwards completes with correct data. Reset asserted in ISSUE gives csb0 = all 1s in the same cycle.

Source files
------------

// File: rtl/wb_openram_pkg.sv
// Shared types and helpers for the banked Wishbone-to-OpenRAM bridge.
package wb_openram_pkg;

    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_ACK
    } state_e;

    // Registered command presented on the shared SRAM port-0 bus
    typedef struct packed {
        logic               web;
        logic [SEL_W-1:0]   wmask;
        logic [SRAM_DW-1:0] din;
    } sram_cmd_t;

    function automatic int unsigned bank_bits(input int unsigned num_banks);
        int unsigned r;
        r = 0;
        if (num_banks > 1) r = $clog2(num_banks);
        return r;
    endfunction

    function automatic int unsigned win_bits(input int unsigned addr_width,
                                             input int unsigned num_banks);
        return addr_width + 2 + bank_bits(num_banks);
    endfunction

endpackage

// File: rtl/wb_openram_rdmux.sv
// Registered NUM_BANKS:1 read-data select; holds its value until the next capture.
module wb_openram_rdmux
    import wb_openram_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned BANK_IDX_W = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cap_en,
    input  logic [BANK_IDX_W-1:0]          bank,
    input  logic [NUM_BANKS*SRAM_DW-1:0]   dout,
    output logic [SRAM_DW-1:0]             rdata
);

    logic [SRAM_DW-1:0] bank_dout [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_split
        assign bank_dout[b] = dout[b*SRAM_DW +: SRAM_DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (cap_en) begin
            rdata <= bank_dout[bank];
        end
    end

endmodule

// File: rtl/wb_openram_banked_bridge.sv
// Wishbone-classic slave mapping an aligned address window onto NUM_BANKS
// single-port OpenRAM macros sharing one command bus.
module wb_openram_banked_bridge
    import wb_openram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WAIT    = 0
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_ni,
    input  logic                           wbs_cyc_i,
    input  logic                           wbs_stb_i,
    input  logic                           wbs_we_i,
    input  logic [SEL_W-1:0]               wbs_sel_i,
    input  logic [31:0]                    wbs_adr_i,
    input  logic [SRAM_DW-1:0]             wbs_dat_i,
    output logic                           wbs_ack_o,
    output logic [SRAM_DW-1:0]             wbs_dat_o,
    output logic [NUM_BANKS-1:0]           clk0,
    output logic [NUM_BANKS-1:0]           csb0,
    output logic                           web0,
    output logic [SEL_W-1:0]               wmask0,
    output logic [ADDR_WIDTH-1:0]          addr0,
    output logic [SRAM_DW-1:0]             din0,
    input  logic [NUM_BANKS*SRAM_DW-1:0]   dout0
);

    localparam int unsigned BANK_BITS  = bank_bits(NUM_BANKS);
    localparam int unsigned WIN_BITS   = win_bits(ADDR_WIDTH, NUM_BANKS);
    localparam int unsigned BANK_IDX_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned CNT_LAST   = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]    csb_q, csb_d;
    logic                    ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BANK_IDX_W-1:0]   bank_q, bank_d;
    sram_cmd_t               cmd_q, cmd_d;
    logic                    cap_en_c;
    logic                    hit_c;
    logic [BANK_IDX_W-1:0]   req_bank_c;
    logic                    unused_adr;

    assign hit_c = wbs_cyc_i & wbs_stb_i
                 & (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign unused_adr = ^wbs_adr_i[1:0];

    if (BANK_BITS > 0) begin : g_bank
        assign req_bank_c = wbs_adr_i[WIN_BITS-1:ADDR_WIDTH+2];
    end else begin : g_single
        assign req_bank_c = '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            csb_q   <= '1;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            bank_q  <= '0;
            cmd_q   <= '{web: 1'b1, wmask: '0, din: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csb_q   <= csb_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next state plus next values of every registered SRAM/Wishbone output
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        csb_d    = '1;
        ack_d    = 1'b0;
        addr_d   = addr_q;
        bank_d   = bank_q;
        cmd_d    = cmd_q;
        cap_en_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The ack cycle itself still sees the old request; skip it
                if (hit_c && !ack_q) begin
                    addr_d      = wbs_adr_i[ADDR_WIDTH+1:2];
                    bank_d      = req_bank_c;
                    cmd_d.web   = ~wbs_we_i;
                    cmd_d.wmask = wbs_we_i ? wbs_sel_i : '0;
                    cmd_d.din   = wbs_dat_i;
                    csb_d       = ~(NUM_BANKS'(1) << req_bank_c);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (!wbs_cyc_i)          state_d = ST_IDLE;
                else if (!cmd_q.web)     state_d = ST_ACK;
                else if (RD_WAIT > 0)    state_d = ST_WAIT;
                else                     state_d = ST_CAPTURE;
            end
            ST_WAIT: begin
                if (!wbs_cyc_i)                         state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(CNT_LAST))     state_d = ST_CAPTURE;
                else                                    cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_CAPTURE: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cap_en_c = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    wb_openram_rdmux #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_IDX_W (BANK_IDX_W)
    ) u_rdmux (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .cap_en (cap_en_c),
        .bank   (bank_q),
        .dout   (dout0),
        .rdata  (wbs_dat_o)
    );

    assign clk0      = {NUM_BANKS{wb_clk_i}};
    assign csb0      = csb_q;
    assign web0      = cmd_q.web;
    assign wmask0    = cmd_q.wmask;
    assign din0      = cmd_q.din;
    assign addr0     = addr_q;
    assign wbs_ack_o = ack_q;

endmodule

// File: tb/tb_wb_openram_banked_bridge.sv
// Scoreboard bench: driver pushes expected acks, monitor pops and compares.
module tb_wb_openram_banked_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NB  = 2;
    localparam int AW  = 8;
    localparam int RDW = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] WIN = 32'(NB * DEPTH * 4);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [NB-1:0]    clk0, csb0;
    logic             web0;
    logic [3:0]       wmask0;
    logic [AW-1:0]    addr0;
    logic [31:0]      din0;
    logic [NB*32-1:0] dout0;

    always #5 clk = ~clk;

    wb_openram_banked_bridge #(
        .BASE_ADDR  (BASE),
        .NUM_BANKS  (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .RD_WAIT    (RDW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .clk0      (clk0),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    // Behavioural OpenRAM macros, port 0, registered read data
    logic [31:0] sram [NB][DEPTH];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < DEPTH; w++) sram[b][w] <= '0;
            dout0 <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (!csb0[b]) begin
                    if (!web0) begin
                        for (int i = 0; i < 4; i++)
                            if (wmask0[i]) sram[b][addr0][8*i +: 8] <= din0[8*i +: 8];
                    end else begin
                        dout0[32*b +: 32] <= sram[b][addr0];
                    end
                end
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        bit          rd;
        logic [31:0] dat;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [NB*DEPTH];
    logic [31:0] last_rd;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_latency", 64'(cyc_cnt - mon_e.t0), 64'(mon_e.lat));
                chk(mon_e.rd ? "read_data" : "dat_hold_on_write", wbs_dat_o, mon_e.dat);
            end
        end
    end

    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        exp_t          e;
        bit            hit, got;
        int            idx, bank, word;
        logic [NB-1:0] exp_csb, ones;
        hit  = (a >= BASE) && (a < BASE + WIN);
        idx  = int'((a - BASE) >> 2);
        bank = idx / DEPTH;
        word = idx % DEPTH;
        ones = '1;
        exp_csb = '1;
        if (hit) exp_csb[bank] = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        if (hit) begin
            e.t0 = cyc_cnt;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
                e.rd = 1'b0; e.dat = last_rd; e.lat = 3;
            end else begin
                e.rd = 1'b1; e.dat = ref_mem[idx]; e.lat = 4 + RDW;
                last_rd = e.dat;
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        chk("csb_issue", csb0, exp_csb);
        if (hit) begin
            chk("addr0", addr0, word);
            chk("web0", web0, !w);
            chk("wmask0", wmask0, w ? s : 4'h0);
            if (w) chk("din0", din0, d);
        end
        @(posedge clk); #1;
        chk("csb_one_cycle", csb0, ones);
        got = 1'b0;
        if (hit) begin
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = wbs_ack_o;
            end
            if (!got) chk("ack_timeout", 64'd0, 64'd1);
        end else begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (wbs_ack_o || csb0 != ones) got = 1'b1;
            end
            chk("miss_quiet", got, 1'b0);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Drop cyc after n edges; a write aborted in ISSUE still commits
    task automatic abort_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input int n, input string nm);
        bit got;
        int idx;
        idx = int'((a - BASE) >> 2);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = 4'hF; dat = d;
        repeat (n) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (w) ref_mem[idx] = d;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbs_ack_o) got = 1'b1;
        end
        chk({nm, "_no_ack"}, got, 1'b0);
        chk({nm, "_dat_hold"}, wbs_dat_o, last_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [NB-1:0] ones;
        ones = '1;
        rst_n = 1'b0; mem_clr = 1'b1; last_rd = '0;
        for (int i = 0; i < NB*DEPTH; i++) ref_mem[i] = '0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_csb", csb0, ones);
        chk("reset_ack", wbs_ack_o, 1'b0);
        chk("reset_dat", wbs_dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0; mem_clr = 1'b0; rst_n = 1'b1;

        xfer(1'b1, BASE + 32'h404, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, BASE + 32'h404, 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'h010, 4'hF, 32'h1122_3344);
        xfer(1'b1, BASE + 32'h010, 4'b0101, 32'hAABB_CCDD);
        xfer(1'b0, BASE + 32'h010, 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'h010, 4'h0, 32'hFFFF_FFFF);
        xfer(1'b0, BASE + 32'h013, 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'h020, 4'hF, 32'h5A5A_0FF0);
        xfer(1'b0, BASE + 32'h020, 4'hF, 32'h0);
        xfer(1'b0, BASE + WIN, 4'hF, 32'h0);
        xfer(1'b1, BASE - 32'd4, 4'hF, 32'h1234_5678);

        abort_xfer(1'b0, BASE + 32'h404, 32'h0, 2, "abort_wait");
        xfer(1'b0, BASE + 32'h404, 4'hF, 32'h0);
        abort_xfer(1'b0, BASE + 32'h010, 32'h0, 4, "abort_capture");
        abort_xfer(1'b1, BASE + 32'h408, 32'hCAFE_F00D, 1, "abort_issue");
        xfer(1'b0, BASE + 32'h408, 4'hF, 32'h0);

        // Reset asserted while the access is in ISSUE
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h020; sel = 4'hF;
        @(posedge clk); #1;
        chk("issue_before_reset", csb0, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_csb", csb0, ones);
        chk("reset_mid_ack", wbs_ack_o, 1'b0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = '0;
        chk("reset_mid_dat", wbs_dat_o, 32'h0);
        repeat (8) @(negedge clk);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                ra = BASE + WIN + 32'($urandom_range(0, 255) << 2);
            end else begin
                ra = BASE + 32'($urandom_range(0, NB-1) * DEPTH * 4)
                          + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            end
            xfer(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
